// File: rtl/link_pkg.sv
// Shared types and defaults for the receive side of the two-board game link.
package link_pkg;

    localparam int POWER_W_DEFAULT = 5;

    typedef enum logic {
        IDLE  = 1'b0,
        THROW = 1'b1
    } link_rx_state_t;

endpackage

// File: rtl/link_sync_filter.sv
// Two-flop synchroniser followed by a stability filter: the output only follows the
// synchronised input once it has held a new value for STABLE_CYCLES cycles.
module link_sync_filter #(
    parameter int W             = 1,
    parameter int STABLE_CYCLES = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         settled
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);

    logic [W-1:0]  s1;
    logic [W-1:0]  s2;
    logic [W-1:0]  held;
    logic [1:0]    prime;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;

    // cnt is the number of consecutive cycles s2 has held its present value.
    // Counting waits until the synchroniser holds real samples, not reset zeros.
    always_comb begin
        cnt_next = cnt;
        if (prime[1]) begin
            if (s2 != held) begin
                cnt_next = CW'(1);
            end else if (cnt != CNT_MAX) begin
                cnt_next = cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1      <= '0;
            s2      <= '0;
            held    <= '0;
            prime   <= '0;
            cnt     <= '0;
            dout    <= '0;
            settled <= 1'b0;
        end else begin
            s1    <= din;
            s2    <= s1;
            held  <= s2;
            prime <= {prime[0], 1'b1};
            cnt   <= cnt_next;
            if (cnt_next == CNT_MAX) begin
                settled <= 1'b1;
                if (s2 != dout) begin
                    dout <= s2;
                end
            end
        end
    end

endmodule

// File: rtl/link_rx.sv
// Receive side of the game link: filters the peer's raw lines and turns throw-flag
// edges into throw_start / throw_end events with the throw power latched.
module link_rx
    import link_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int POWER_W       = POWER_W_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_player1_ready,
    input  logic               in_player2_ready,
    input  logic [POWER_W-1:0] in_power,
    input  logic               in_throw_flag,
    output logic               player1_ready,
    output logic               player2_ready,
    output logic [POWER_W-1:0] power,
    output logic               power_valid,
    output logic               throw_start,
    output logic               throw_end,
    output logic               throw_active,
    output logic               power_mismatch
);

    logic               flag_f;
    logic [POWER_W-1:0] power_f;
    logic               p1_settled;
    logic               p2_settled;
    logic               flag_settled;
    logic               power_settled;
    logic               link_settled;

    link_sync_filter #(.W(1), .STABLE_CYCLES(STABLE_CYCLES)) u_p1 (
        .clk(clk), .rst(rst), .din(in_player1_ready),
        .dout(player1_ready), .settled(p1_settled)
    );

    link_sync_filter #(.W(1), .STABLE_CYCLES(STABLE_CYCLES)) u_p2 (
        .clk(clk), .rst(rst), .din(in_player2_ready),
        .dout(player2_ready), .settled(p2_settled)
    );

    link_sync_filter #(.W(1), .STABLE_CYCLES(STABLE_CYCLES)) u_flag (
        .clk(clk), .rst(rst), .din(in_throw_flag),
        .dout(flag_f), .settled(flag_settled)
    );

    link_sync_filter #(.W(POWER_W), .STABLE_CYCLES(STABLE_CYCLES)) u_power (
        .clk(clk), .rst(rst), .din(in_power),
        .dout(power_f), .settled(power_settled)
    );

    assign link_settled = p1_settled & p2_settled & flag_settled & power_settled;

    link_rx_state_t     state;
    logic               flag_prev;
    logic               armed;
    logic [POWER_W-1:0] power_prev;

    // A throw may only start after a qualified low flag has been seen since reset,
    // so a flag already high when the link comes up is ignored until it cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            flag_prev      <= 1'b0;
            armed          <= 1'b0;
            power_prev     <= '0;
            power          <= '0;
            power_valid    <= 1'b0;
            throw_start    <= 1'b0;
            throw_end      <= 1'b0;
            throw_active   <= 1'b0;
            power_mismatch <= 1'b0;
        end else begin
            throw_start    <= 1'b0;
            throw_end      <= 1'b0;
            power_mismatch <= 1'b0;
            flag_prev      <= flag_f;
            power_prev     <= power_f;
            if (link_settled && !flag_f) begin
                armed <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (armed && flag_f && !flag_prev) begin
                        power        <= power_f;
                        power_valid  <= 1'b1;
                        throw_start  <= 1'b1;
                        throw_active <= 1'b1;
                        state        <= THROW;
                    end
                end
                THROW: begin
                    if (power_f != power_prev) begin
                        power_mismatch <= 1'b1;
                    end
                    if (!flag_f) begin
                        throw_end    <= 1'b1;
                        throw_active <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_link_rx.sv
// Directed bench for link_rx: hand-written latency sequences plus a vector table.
module tb_link_rx;
  localparam int PW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_player1_ready = 1'b1;
  logic          in_player2_ready = 1'b1;
  logic [PW-1:0] in_power = '1;
  logic          in_throw_flag = 1'b1;
  logic          player1_ready;
  logic          player2_ready;
  logic [PW-1:0] power;
  logic          power_valid;
  logic          throw_start;
  logic          throw_end;
  logic          throw_active;
  logic          power_mismatch;

  int checks = 0;
  int failures = 0;
  int n_start = 0;
  int n_end = 0;
  int n_mm = 0;
  logic [PW-1:0] exp_q[$];

  link_rx #(.STABLE_CYCLES(4), .POWER_W(PW)) dut (
    .clk(clk), .rst(rst),
    .in_player1_ready(in_player1_ready), .in_player2_ready(in_player2_ready),
    .in_power(in_power), .in_throw_flag(in_throw_flag),
    .player1_ready(player1_ready), .player2_ready(player2_ready),
    .power(power), .power_valid(power_valid),
    .throw_start(throw_start), .throw_end(throw_end),
    .throw_active(throw_active), .power_mismatch(power_mismatch)
  );

  // clock/reset block
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // scoreboard: pulse counters and the captured power of every throw_start
  always @(negedge clk) begin
    if (throw_end === 1'b1) n_end++;
    if (power_mismatch === 1'b1) n_mm++;
    if (throw_start === 1'b1) begin
      n_start++;
      if (exp_q.size() == 0) begin
        check("unexpected_throw_start", 32'd1, 32'd0);
      end else begin
        check("captured_power", 32'(power), 32'(exp_q.pop_front()));
      end
    end
  end

  // driver tasks
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input logic p1, input logic p2, input logic [PW-1:0] pw, input logic fl);
    in_player1_ready = p1;
    in_player2_ready = p2;
    in_power = pw;
    in_throw_flag = fl;
  endtask

  typedef struct {
    logic          p1;
    logic          p2;
    logic [PW-1:0] pw;
    logic          fl;
    int            wait_cyc;
    logic          e_p1;
    logic          e_p2;
    logic          e_act;
    logic [PW-1:0] e_pw;
    logic          e_pv;
    int            ds;
    int            de;
    int            dm;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int s0, e0, m0;

    vecs[0] = '{1'b1, 1'b0, 5'd7,  1'b1, 10, 1'b1, 1'b0, 1'b0, 5'd0,  1'b0, 0, 0, 0};
    vecs[1] = '{1'b1, 1'b1, 5'd7,  1'b0, 10, 1'b1, 1'b1, 1'b0, 5'd0,  1'b0, 0, 0, 0};
    vecs[2] = '{1'b0, 1'b1, 5'd25, 1'b0, 10, 1'b0, 1'b1, 1'b0, 5'd0,  1'b0, 0, 0, 0};
    vecs[3] = '{1'b0, 1'b1, 5'd25, 1'b1, 10, 1'b0, 1'b1, 1'b1, 5'd25, 1'b1, 1, 0, 0};
    vecs[4] = '{1'b1, 1'b0, 5'd25, 1'b1, 10, 1'b1, 1'b0, 1'b1, 5'd25, 1'b1, 0, 0, 0};
    vecs[5] = '{1'b1, 1'b0, 5'd31, 1'b1, 10, 1'b1, 1'b0, 1'b1, 5'd25, 1'b1, 0, 0, 1};
    vecs[6] = '{1'b0, 1'b0, 5'd31, 1'b0, 10, 1'b0, 1'b0, 1'b0, 5'd25, 1'b1, 0, 1, 0};
    vecs[7] = '{1'b0, 1'b0, 5'd12, 1'b1, 10, 1'b0, 1'b0, 1'b1, 5'd12, 1'b1, 1, 0, 0};
    vecs[8] = '{1'b0, 1'b0, 5'd12, 1'b0, 10, 1'b0, 1'b0, 1'b0, 5'd12, 1'b1, 0, 1, 0};

    // reset held 3 cycles with every raw input high
    step(3);
    check("rst_p1", 32'(player1_ready), 32'd0);
    check("rst_p2", 32'(player2_ready), 32'd0);
    check("rst_power", 32'(power), 32'd0);
    check("rst_pv", 32'(power_valid), 32'd0);
    check("rst_start", 32'(throw_start), 32'd0);
    check("rst_end", 32'(throw_end), 32'd0);
    check("rst_active", 32'(throw_active), 32'd0);
    check("rst_mm", 32'(power_mismatch), 32'd0);
    rst = 1'b0;
    step(5);
    check("ready_before_lat", 32'({player1_ready, player2_ready}), 32'd0);
    step(1);
    check("ready_at_lat", 32'({player1_ready, player2_ready}), 32'd3);
    step(10);
    check("no_start_flag_high_from_reset", 32'(n_start), 32'd0);
    check("idle_after_reset", 32'(throw_active), 32'd0);

    // short glitch on player 1 ready is swallowed
    drive(1'b0, 1'b1, 5'd0, 1'b0);
    step(12);
    check("p1_low", 32'(player1_ready), 32'd0);
    in_player1_ready = 1'b1;
    step(2);
    in_player1_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      check("p1_glitch", 32'(player1_ready), 32'd0);
    end

    // pulse of exactly 4 cycles reaches the output 5 edges after its first sample
    in_player1_ready = 1'b1;
    step(4);
    in_player1_ready = 1'b0;
    check("p1_pulse_n3", 32'(player1_ready), 32'd0);
    step(1);
    check("p1_pulse_n4", 32'(player1_ready), 32'd0);
    step(1);
    check("p1_pulse_n5", 32'(player1_ready), 32'd1);
    step(1);
    check("p1_pulse_n6", 32'(player1_ready), 32'd1);
    step(10);
    check("p1_pulse_gone", 32'(player1_ready), 32'd0);

    // throw with power 19
    in_power = 5'd19;
    step(10);
    exp_q.push_back(5'd19);
    in_throw_flag = 1'b1;
    step(6);
    check("start_early", 32'(throw_start), 32'd0);
    check("active_early", 32'(throw_active), 32'd0);
    step(1);
    check("start_pulse", 32'(throw_start), 32'd1);
    check("start_power", 32'(power), 32'd19);
    check("start_pv", 32'(power_valid), 32'd1);
    check("start_active", 32'(throw_active), 32'd1);
    step(1);
    check("start_one_cycle", 32'(throw_start), 32'd0);

    // power change during the throw
    m0 = n_mm;
    in_power = 5'd7;
    step(16);
    check("mismatch_count", 32'(n_mm - m0), 32'd1);
    check("power_held", 32'(power), 32'd19);
    check("still_active", 32'(throw_active), 32'd1);

    // flag drop ends the throw
    e0 = n_end;
    in_throw_flag = 1'b0;
    step(10);
    check("end_count", 32'(n_end - e0), 32'd1);
    check("end_active", 32'(throw_active), 32'd0);
    check("end_pv", 32'(power_valid), 32'd1);
    check("end_power", 32'(power), 32'd19);

    // reset in the middle of a throw
    exp_q.push_back(5'd7);
    in_throw_flag = 1'b1;
    step(10);
    check("throw2_active", 32'(throw_active), 32'd1);
    check("throw2_power", 32'(power), 32'd7);
    e0 = n_end;
    s0 = n_start;
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check("midrst_active", 32'(throw_active), 32'd0);
    check("midrst_power", 32'(power), 32'd0);
    check("midrst_pv", 32'(power_valid), 32'd0);
    check("midrst_end", 32'(throw_end), 32'd0);
    step(15);
    check("midrst_no_end", 32'(n_end - e0), 32'd0);
    check("midrst_no_start", 32'(n_start - s0), 32'd0);

    // vector table
    foreach (vecs[i]) begin
      s0 = n_start;
      e0 = n_end;
      m0 = n_mm;
      if (vecs[i].ds != 0) exp_q.push_back(vecs[i].pw);
      drive(vecs[i].p1, vecs[i].p2, vecs[i].pw, vecs[i].fl);
      step(vecs[i].wait_cyc);
      check($sformatf("v%0d_p1", i), 32'(player1_ready), 32'(vecs[i].e_p1));
      check($sformatf("v%0d_p2", i), 32'(player2_ready), 32'(vecs[i].e_p2));
      check($sformatf("v%0d_active", i), 32'(throw_active), 32'(vecs[i].e_act));
      check($sformatf("v%0d_power", i), 32'(power), 32'(vecs[i].e_pw));
      check($sformatf("v%0d_pv", i), 32'(power_valid), 32'(vecs[i].e_pv));
      check($sformatf("v%0d_starts", i), 32'(n_start - s0), 32'(vecs[i].ds));
      check($sformatf("v%0d_ends", i), 32'(n_end - e0), 32'(vecs[i].de));
      check($sformatf("v%0d_mismatches", i), 32'(n_mm - m0), 32'(vecs[i].dm));
    end

    check("exp_q_drained", 32'(exp_q.size()), 32'd0);

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
